// File: rtl/sram_read_streamer_pkg.sv
// Shared types and constants for the SRAM read streamer and its FIFO.
package sram_read_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // A burst length needs one more bit than an address so that a full
    // 2^ADDR_WIDTH burst can be expressed.
    function automatic int len_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sram_read_streamer_stream_fifo2.sv
// Two-entry register FIFO with occupancy count. Entry 0 is always the head,
// so the head data comes straight from a flop. Push and pop may coincide.
module stream_fifo2
    import sram_read_streamer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;

    assign head_data = entry0;

    // Shift-style storage: pops move entry1 forward, pushes land behind the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count != FULL) begin
                        if (count == 2'd0) begin
                            entry0 <= push_data;
                        end else begin
                            entry1 <= push_data;
                        end
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        entry0 <= entry1;
                        count  <= count - 2'd1;
                    end
                end
                2'b11: begin
                    if (count == FULL) begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end else if (count != 2'd0) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= push_data;
                        count  <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_read_streamer.sv
// Streams a burst of consecutive SRAM words out as a valid/ready stream.
// Reads are issued only when the word can be guaranteed a FIFO slot, so the
// two-entry buffer covers the one-cycle SRAM latency at full throughput.
module sram_read_streamer
    import sram_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_csb,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int LEN_W = len_w(ADDR_WIDTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_W-1:0]      issue_rem;
    logic [LEN_W-1:0]      out_rem;
    logic                  inflight;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  issue;

    // Occupancy after this cycle's pop, counting the word still in the SRAM pipe.
    assign pop       = out_valid & out_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (issue_rem != '0) && (occupancy < 3'd2);

    assign sram_csb   = ~issue;
    assign sram_raddr = addr;
    assign out_valid  = (fifo_count != 2'd0);
    assign out_last   = (out_rem == LEN_W'(1)) & out_valid;

    // Remember that a read was issued so its data is captured next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // Burst control: latch the request, track issued and delivered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            issue_rem <= '0;
            out_rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            addr      <= base_addr;
                            issue_rem <= length;
                            out_rem   <= length;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr      <= addr + 1'b1;
                        issue_rem <= issue_rem - 1'b1;
                    end
                    if (pop) begin
                        out_rem <= out_rem - 1'b1;
                        if (out_rem == LEN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    stream_fifo2 #(
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data(sram_rdata),
        .pop      (pop),
        .head_data(out_data),
        .count    (fifo_count)
    );

endmodule

// File: doc/sram_read_streamer.md
Name: sram_read_streamer

Overview:
- Downstream consumer of the single-port-read activation/weight SRAM.
- On `start`, reads `length` consecutive words beginning at `base_addr` through the SRAM read port (chip-select active low, 1-cycle registered read).
- Presents the words as a valid/ready stream to the systolic-array operand feeder.
- A 2-entry output buffer absorbs the SRAM read latency, so the stream runs at one word per cycle with full backpressure support.

Parameters:
- DATA_WIDTH, 32, SRAM word width and stream data width.
- ADDR_WIDTH, 10, SRAM address width; length is ADDR_WIDTH+1 bits so a full 2^ADDR_WIDTH burst is expressible.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a burst when idle.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  ADDR_WIDTH+1  word count, sampled with start; 0 is legal.
- busy  out  1  high while a burst is active.
- done  out  1  one-cycle pulse at burst completion.
- sram_csb  out  1  to SRAM csb; low only on cycles that issue a read.
- sram_raddr  out  ADDR_WIDTH  to SRAM raddr.
- sram_rdata  in  DATA_WIDTH  from SRAM rdata; valid the cycle after the csb-low cycle.
- out_valid  out  1  stream valid.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  qualifies the final word of the burst.
- out_ready  in  1  stream ready from consumer.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, busy=0, done=0, sram_csb=1, sram_raddr=0, out_valid=0, out_data=0, out_last=0.
  - FIFO emptied, in-flight flag cleared, counters zeroed.
- Reset mid-burst aborts the burst. No done pulse. Discarded words are never emitted.
- This block never drives the SRAM write enable; the write port belongs to the loader.
- States:
  - IDLE: start=1 with length>0 → RUN; latch addr=base_addr, issue_rem=length, out_rem=length. start=1 with length=0 → DONE, with no SRAM access.
  - RUN: stays until out_rem reaches 0 on a handshake, then → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start is ignored outside IDLE.
- busy=1 in RUN only.
- Issue rule, evaluated in RUN:
  - pop = out_valid & out_ready.
  - Issue when issue_rem>0 and (fifo_count + inflight − pop) < 2.
  - On issue: sram_csb=0 (combinational), sram_raddr=addr, addr+1 (mod 2^ADDR_WIDTH), issue_rem−1, inflight←1 for the next cycle.
  - Otherwise sram_csb=1.
- Capture: when inflight=1, sram_rdata is pushed into the FIFO at that cycle's end.
  - The credit rule guarantees no overflow, so push into a full FIFO cannot occur.
  - Simultaneous push and pop is legal.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last = (out_rem==1) & out_valid.
  - Each handshake decrements out_rem.
- Latency:
  - start in cycle 0 → first csb-low in cycle 1 → rdata in cycle 2 → out_valid in cycle 3.
  - With out_ready held high, one word per cycle and no bubbles.
  - done asserts the cycle after the last handshake.
- Address wrap: base_addr + length > 2^ADDR_WIDTH wraps to 0; no error flag.
- Backpressure: out_data/out_last must be held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package: state enum (IDLE, RUN, DONE); localparam FIFO_DEPTH=2; width helper LEN_W=ADDR_WIDTH+1.
- One sub-module: stream_fifo2 (2-entry register FIFO with count output, push/pop, simultaneous push+pop), reused by other operand feeders.

Test Plan:
- Preload SRAM mem[i]=i+100. Start base=5, length=4, out_ready=1 → out_valid first in cycle 3. out_data 105,106,107,108 on consecutive cycles. out_last on 108. done one cycle later. busy high cycles 1..6.
- length=0 → done pulses in cycle 1; busy never high; sram_csb never low; out_valid never high.
- base=4, length=6, out_ready toggling 1,0,0,1,… → data 104..109 in order, none lost or duplicated, held stable while stalled. csb-low count equals 6. Never more than 2 words buffered plus in flight.
- Wrap: ADDR_WIDTH=10, base=1022, length=4 → addresses 1022, 1023, 0, 1; data matches the SRAM contents at those addresses.
- Start pulse during RUN with a different base → ignored; the original burst completes unchanged.
- Assert rst_n=0 mid-burst after 2 words → outputs return to reset values immediately. No done pulse. A new burst after reset streams correctly from its own base.
